// File: rtl/tick_divider_if.sv
// Bus for tick_divider: run enable, programmable divisor load, and all tick/square outputs.
//   master: drives en, prog_div, prog_load; observes tick, sq, prog_pending, prog_tick, prog_sq
//   slave : the divider itself
interface tick_divider_if #(
  parameter int unsigned CNT_W  = 27,
  parameter int unsigned NUM_CH = 2
) ();

  logic              en;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [CNT_W-1:0]  prog_div;
  logic              prog_load;
  logic              prog_pending;
  logic              prog_tick;
  logic              prog_sq;

  modport master (
    output en, prog_div, prog_load,
    input  tick, sq, prog_pending, prog_tick, prog_sq
  );

  modport slave (
    input  en, prog_div, prog_load,
    output tick, sq, prog_pending, prog_tick, prog_sq
  );

endinterface

// File: rtl/tick_divider.sv
// Multi-channel clock-enable generator: NUM_CH fixed-rate channels plus one
// run-time programmable channel. Each channel emits a one-cycle tick every D
// enabled cycles and a square wave toggling on each tick.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : tick_divider_if.slave (en, tick, sq, prog_div, prog_load,
//          prog_pending, prog_tick, prog_sq); all outputs registered
module tick_divider #(
  parameter int unsigned              CNT_W        = 27,
  parameter int unsigned              NUM_CH       = 2,
  parameter logic [NUM_CH*CNT_W-1:0]  DIV_VEC      = {27'd50_000_000, 27'd100_000},
  parameter logic [CNT_W-1:0]         PROG_RST_DIV = 27'd10_000_000
) (
  input logic          clk,
  input logic          rst,
  tick_divider_if.slave bus
);

  // Terminal count for a divisor; a divisor of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] eff_lim(input logic [CNT_W-1:0] div);
    eff_lim = (div == '0) ? '0 : div - CNT_W'(1);
  endfunction

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;
  logic [NUM_CH-1:0]            sq_q, sq_d;

  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;       // active programmable divisor
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_q, pend_d;
  logic             ptick_q, ptick_d;
  logic             psq_q, psq_d;
  logic             pwrap_c;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      tick_q     <= '0;
      sq_q       <= '0;
      pcnt_q     <= '0;
      pdiv_q     <= PROG_RST_DIV;
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      ptick_q    <= 1'b0;
      psq_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
      pcnt_q     <= pcnt_d;
      pdiv_q     <= pdiv_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      ptick_q    <= ptick_d;
      psq_q      <= psq_d;
    end
  end

  // Fixed channels
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = '0;
    sq_d   = sq_q;
    if (bus.en) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (cnt_q[i] == eff_lim(DIV_VEC[i*CNT_W +: CNT_W])) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          sq_d[i]   = ~sq_q[i];
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign pwrap_c = bus.en && (pcnt_q == eff_lim(pdiv_q));

  // Programmable channel; a new divisor only takes effect at a wrap so no
  // period is ever truncated or stretched. A load coinciding with the wrap
  // bypasses the pending register and is applied immediately.
  always_comb begin
    pcnt_d     = pcnt_q;
    pdiv_d     = pdiv_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    ptick_d    = 1'b0;
    psq_d      = psq_q;

    if (bus.prog_load) begin
      pend_div_d = bus.prog_div;
      pend_d     = 1'b1;
    end

    if (pwrap_c) begin
      pcnt_d  = '0;
      ptick_d = 1'b1;
      psq_d   = ~psq_q;
      if (bus.prog_load) begin
        pdiv_d = bus.prog_div;
      end else if (pend_q) begin
        pdiv_d = pend_div_q;
      end
      pend_d = 1'b0;
    end else if (bus.en) begin
      pcnt_d = pcnt_q + CNT_W'(1);
    end
  end

  assign bus.tick         = tick_q;
  assign bus.sq           = sq_q;
  assign bus.prog_pending = pend_q;
  assign bus.prog_tick    = ptick_q;
  assign bus.prog_sq      = psq_q;

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider with CNT_W=8, DIV_VEC={3,4}, PROG_RST_DIV=5.
module tb_tick_divider;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned NUM_CH = 2;

  logic clk;
  logic rst;

  tick_divider_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) bus ();

  tick_divider #(
    .CNT_W       (CNT_W),
    .NUM_CH      (NUM_CH),
    .DIV_VEC     ({8'd3, 8'd4}),
    .PROG_RST_DIV(8'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] div;
    logic [1:0] tick;
    logic [1:0] sq;
    logic       pt;
    logic       psq;
    logic       pend;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic en, input logic load, input logic [7:0] div,
                     input logic [1:0] tick, input logic [1:0] sq,
                     input logic pt, input logic psq, input logic pend);
    vec_t v;
    v.en = en; v.load = load; v.div = div; v.tick = tick; v.sq = sq;
    v.pt = pt; v.psq = psq; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, bus.tick, bus.sq, bus.prog_tick, bus.prog_sq, bus.prog_pending};
  endfunction

  initial begin
    int n;
    logic [31:0] exp;

    // en load div   tick  sq   pt psq pend   (outputs after the edge)
    // free run from reset
    add(1,0,0, 2'b00,2'b00,0,0,0);  // 1
    add(1,0,0, 2'b00,2'b00,0,0,0);
    add(1,0,0, 2'b10,2'b10,0,0,0);
    add(1,0,0, 2'b01,2'b11,0,0,0);
    add(1,0,0, 2'b00,2'b11,1,1,0);  // 5
    add(1,0,0, 2'b10,2'b01,0,1,0);
    add(1,0,0, 2'b00,2'b01,0,1,0);
    add(1,0,0, 2'b01,2'b00,0,1,0);
    add(1,0,0, 2'b10,2'b10,0,1,0);
    add(1,0,0, 2'b00,2'b10,1,0,0);  // 10
    add(1,0,0, 2'b00,2'b10,0,0,0);
    add(1,0,0, 2'b11,2'b01,0,0,0);
    add(1,0,0, 2'b00,2'b01,0,0,0);
    add(1,0,0, 2'b00,2'b01,0,0,0);  // 14: ch0 count now 2
    // enable gap of 7 cycles
    for (int i = 0; i < 7; i++) add(0,0,0, 2'b00,2'b01,0,0,0);
    add(1,0,0, 2'b10,2'b11,1,1,0);  // 22
    add(1,0,0, 2'b01,2'b10,0,1,0);  // 23: ch0 ticks 2 cycles after resume
    // load 2 while prog count = 1
    add(1,1,2, 2'b00,2'b10,0,1,1);  // 24
    add(1,0,0, 2'b10,2'b00,0,1,1);
    add(1,0,0, 2'b00,2'b00,0,1,1);
    add(1,0,0, 2'b01,2'b01,1,0,0);  // 27: period 5 preserved, divisor 2 applied
    add(1,0,0, 2'b10,2'b11,0,0,0);
    add(1,0,0, 2'b00,2'b11,1,1,0);
    add(1,0,0, 2'b00,2'b11,0,1,0);
    add(1,0,0, 2'b11,2'b00,1,0,0);  // 31
    // load 0 in the wrap cycle
    add(1,0,0, 2'b00,2'b00,0,0,0);
    add(1,1,0, 2'b00,2'b00,1,1,0);  // 33
    add(1,0,0, 2'b10,2'b10,1,0,0);
    add(1,0,0, 2'b01,2'b11,1,1,0);
    add(1,0,0, 2'b00,2'b11,1,0,0);  // 36
    // load 3 at wrap, then 7 and 9 while pending
    add(1,1,3, 2'b10,2'b01,1,1,0);  // 37
    add(1,1,7, 2'b00,2'b01,0,1,1);
    add(1,1,9, 2'b01,2'b00,0,1,1);
    add(1,0,0, 2'b10,2'b10,1,0,0);  // 40: 9 applied
    add(1,0,0, 2'b00,2'b10,0,0,0);
    add(1,0,0, 2'b00,2'b10,0,0,0);
    add(1,0,0, 2'b11,2'b01,0,0,0);
    add(1,0,0, 2'b00,2'b01,0,0,0);
    add(1,0,0, 2'b00,2'b01,0,0,0);
    add(1,0,0, 2'b10,2'b11,0,0,0);
    add(1,0,0, 2'b01,2'b10,0,0,0);  // 47: would tick here if 7 had been applied
    add(1,0,0, 2'b00,2'b10,0,0,0);
    add(1,0,0, 2'b10,2'b00,1,1,0);  // 49

    rst = 1'b1;
    bus.en = 1'b0;
    bus.prog_load = 1'b0;
    bus.prog_div = '0;
    #100;
    chk("reset_outputs", outs(), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      bus.en = vecs[i].en;
      bus.prog_load = vecs[i].load;
      bus.prog_div = vecs[i].div;
      step();
      exp = {25'd0, vecs[i].tick, vecs[i].sq, vecs[i].pt, vecs[i].psq, vecs[i].pend};
      chk($sformatf("row%0d", i + 1), outs(), exp);
    end

    // Divisor 9 running, count 0: load 2 and wait for the wrap
    bus.en = 1'b1;
    bus.prog_load = 1'b1;
    bus.prog_div = 8'd2;
    step();
    bus.prog_load = 1'b0;
    chk("pend_set", 32'(bus.prog_pending), 32'd1);
    n = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (bus.prog_tick) begin
        n = k;
        break;
      end
    end
    chk("wrap_latency", 32'(n), 32'd8);
    chk("pend_clear", 32'(bus.prog_pending), 32'd0);
    step();
    chk("div2_low", 32'(bus.prog_tick), 32'd0);
    step();
    chk("div2_high", 32'(bus.prog_tick), 32'd1);

    // Leave a load pending, then reset mid-cycle
    bus.prog_load = 1'b1;
    bus.prog_div = 8'd7;
    step();
    bus.prog_load = 1'b0;
    chk("pend_before_rst", 32'(bus.prog_pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", outs(), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("held_reset", outs(), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("post_rst_pt%0d", k), 32'(bus.prog_tick), ((k % 5) == 0) ? 32'd1 : 32'd0);
    end
    chk("post_rst_pend", 32'(bus.prog_pending), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
